// File: rtl/gameover_ctrl.sv
// gameover_ctrl: sequencer for the game-over overlay stage of the VGA pipeline.
// Watches the game result, counts frames off vsync, and drives the overlay
// enable/colour through blink, steady hold and wait-for-restart phases. It
// issues a one-cycle restart pulse and a freeze flag back to the game logic.
// Optional feature: define GAMEOVER_AUTO_RESTART_EN to restart automatically
// after AUTO_FRAMES frames in WAIT with no button press.
module gameover_ctrl #(
    parameter int          BLINK_FRAMES = 8,
    parameter int          BLINK_COUNT  = 3,
    parameter int          HOLD_FRAMES  = 120,
    parameter int          AUTO_FRAMES  = 600,
    parameter logic [11:0] OVER_RGB     = 12'h820
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  gameover,
    input  logic        vsync,
    input  logic        restart_btn,
    output logic        over_en,
    output logic [11:0] over_rgb,
    output logic [1:0]  winner,
    output logic        freeze,
    output logic        restart
);

    // Counter width covers the largest frame/toggle count used by any state.
    localparam int MAX_A = (BLINK_FRAMES > 2 * BLINK_COUNT) ? BLINK_FRAMES : 2 * BLINK_COUNT;
    localparam int MAX_B = (HOLD_FRAMES > AUTO_FRAMES) ? HOLD_FRAMES : AUTO_FRAMES;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] TOGGLE_LAST = CNT_W'(2 * BLINK_COUNT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_FRAMES - 1);
`ifdef GAMEOVER_AUTO_RESTART_EN
    localparam logic [CNT_W-1:0] AUTO_LAST   = CNT_W'(AUTO_FRAMES - 1);
`endif

    localparam logic [2:0] S_PLAY    = 3'd0;
    localparam logic [2:0] S_BLINK   = 3'd1;
    localparam logic [2:0] S_HOLD    = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_RESTART = 3'd4;

    logic [2:0]       state, state_d;
    logic             vsync_q, btn_q;
    logic             armed, armed_d;
    logic             phase, phase_d;
    logic [CNT_W-1:0] frame_cnt, frame_cnt_d;
    logic [CNT_W-1:0] toggle_cnt, toggle_cnt_d;
    logic [1:0]       winner_d;
    logic             over_en_d, freeze_d, restart_d;
    logic [11:0]      over_rgb_d;
    logic             tick, btn_rise;

    assign tick     = vsync & ~vsync_q;
    assign btn_rise = restart_btn & ~btn_q;

    // Next-state logic: sequence transitions, counters, winner latch.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d      = state;
        armed_d      = armed;
        phase_d      = phase;
        frame_cnt_d  = frame_cnt;
        toggle_cnt_d = toggle_cnt;
        winner_d     = winner;
        case (state)
            S_PLAY: begin
                if (gameover == 2'd0) armed_d = 1'b1;
                if (armed && gameover != 2'd0) begin
                    winner_d     = gameover;
                    armed_d      = 1'b0;
                    frame_cnt_d  = '0;
                    toggle_cnt_d = '0;
                    phase_d      = 1'b1;
                    state_d      = S_BLINK;
                end
            end
            S_BLINK: begin
                if (tick) begin
                    if (frame_cnt == BLINK_LAST) begin
                        frame_cnt_d  = '0;
                        phase_d      = ~phase;
                        toggle_cnt_d = toggle_cnt + 1'b1;
                        if (toggle_cnt == TOGGLE_LAST) begin
                            state_d      = S_HOLD;
                            phase_d      = 1'b1;
                            toggle_cnt_d = '0;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    if (frame_cnt == HOLD_LAST) begin
                        frame_cnt_d = '0;
                        state_d     = S_WAIT;
                    end else begin
                        frame_cnt_d = frame_cnt + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Button beats a coincident tick; the tick is simply dropped.
                if (btn_rise) begin
                    frame_cnt_d = '0;
                    winner_d    = 2'd0;
                    state_d     = S_RESTART;
                end
`ifdef GAMEOVER_AUTO_RESTART_EN
                else if (tick) begin
                    if (frame_cnt == AUTO_LAST) begin
                        frame_cnt_d = '0;
                        winner_d    = 2'd0;
                        state_d     = S_RESTART;
                    end else begin
                        frame_cnt_d = frame_cnt + 1'b1;
                    end
                end
`endif
            end
            S_RESTART: begin
                frame_cnt_d  = '0;
                toggle_cnt_d = '0;
                state_d      = S_PLAY;
            end
            default: begin
                state_d = S_PLAY;
            end
        endcase
    end

    // Output decode from the next state, so outputs follow the state on the same edge.
    always_comb begin
        over_en_d  = 1'b0;
        freeze_d   = 1'b0;
        restart_d  = 1'b0;
        over_rgb_d = 12'h000;
        case (state_d)
            S_BLINK:   begin over_en_d = phase_d; freeze_d = 1'b1; end
            S_HOLD:    begin over_en_d = 1'b1;    freeze_d = 1'b1; end
            S_WAIT:    begin over_en_d = 1'b1;    freeze_d = 1'b1; end
            S_RESTART: begin restart_d = 1'b1;    freeze_d = 1'b1; end
            default:   begin over_en_d = 1'b0;    freeze_d = 1'b0; end
        endcase
        case (winner_d)
            2'd1:    over_rgb_d = OVER_RGB;
            2'd2:    over_rgb_d = 12'h028;
            2'd3:    over_rgb_d = 12'h888;
            default: over_rgb_d = 12'h000;
        endcase
    end

    // State, edge-detect and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state      <= S_PLAY;
            vsync_q    <= 1'b0;
            btn_q      <= 1'b0;
            armed      <= 1'b1;
            phase      <= 1'b0;
            frame_cnt  <= '0;
            toggle_cnt <= '0;
            winner     <= 2'd0;
            over_en    <= 1'b0;
            over_rgb   <= 12'h000;
            freeze     <= 1'b0;
            restart    <= 1'b0;
        end else begin
            state      <= state_d;
            vsync_q    <= vsync;
            btn_q      <= restart_btn;
            armed      <= armed_d;
            phase      <= phase_d;
            frame_cnt  <= frame_cnt_d;
            toggle_cnt <= toggle_cnt_d;
            winner     <= winner_d;
            over_en    <= over_en_d;
            over_rgb   <= over_rgb_d;
            freeze     <= freeze_d;
            restart    <= restart_d;
        end
    end

endmodule

// File: tb/tb_gameover_ctrl.sv
// tb_gameover_ctrl: scoreboard bench for gameover_ctrl with short frame counts.
// Each driven cycle pushes the expected registered outputs; they are popped
// and compared one cycle later, 1 time unit after the clock edge.
module tb_gameover_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  gameover;
    logic        vsync;
    logic        restart_btn;
    logic        over_en;
    logic [11:0] over_rgb;
    logic [1:0]  winner;
    logic        freeze;
    logic        restart;

    typedef struct packed {
        logic        en;
        logic [11:0] rgb;
        logic [1:0]  win;
        logic        frz;
        logic        rs;
    } out_t;

    out_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    gameover_ctrl #(
        .BLINK_FRAMES(2),
        .BLINK_COUNT (2),
        .HOLD_FRAMES (3),
        .AUTO_FRAMES (4),
        .OVER_RGB    (12'h820)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gameover   (gameover),
        .vsync      (vsync),
        .restart_btn(restart_btn),
        .over_en    (over_en),
        .over_rgb   (over_rgb),
        .winner     (winner),
        .freeze     (freeze),
        .restart    (restart)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got {en,rgb,win,frz,rs}=%h expected %h", tag, obs, exp);
        end
    endtask

    function automatic out_t mk(input logic en, input logic [1:0] w, input logic frz, input logic rs);
        out_t o;
        o.en  = en;
        o.win = w;
        o.frz = frz;
        o.rs  = rs;
        case (w)
            2'd1:    o.rgb = 12'h820;
            2'd2:    o.rgb = 12'h028;
            2'd3:    o.rgb = 12'h888;
            default: o.rgb = 12'h000;
        endcase
        return o;
    endfunction

    // One clock: drive inputs, queue expectation, compare after the edge.
    task automatic cycle(input string tag, input logic r, input logic v, input logic b,
                         input logic [1:0] g, input out_t e);
        out_t got;
        out_t want;
        rst         = r;
        vsync       = v;
        restart_btn = b;
        gameover    = g;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = {over_en, over_rgb, winner, freeze, restart};
        want = exp_q.pop_front();
        check(tag, 32'(got), 32'(want));
    endtask

    // One frame: vsync high for a cycle (tick), then low; outputs settle after the tick.
    task automatic frame(input string tag, input logic b, input logic [1:0] g, input out_t e);
        cycle(tag, 1'b0, 1'b1, b, g, e);
        cycle(tag, 1'b0, 1'b0, b, g, e);
    endtask

    // Eight blink ticks: over_en after each tick is 1,0,0,1,1,0,0 then steady 1 (HOLD).
    task automatic run_blink(input logic [1:0] w, input logic [1:0] g);
        logic [7:0] pat;
        pat = 8'b1001_1001;
        for (int i = 0; i < 8; i++)
            frame($sformatf("blink_t%0d", i + 1), 1'b0, g, mk(pat[7-i], w, 1'b1, 1'b0));
    endtask

    task automatic run_hold(input logic [1:0] w, input logic b, input int n);
        for (int i = 0; i < n; i++)
            frame($sformatf("hold_t%0d", i + 1), b, 2'd0, mk(1'b1, w, 1'b1, 1'b0));
    endtask

    initial begin
        out_t z;
        z = mk(1'b0, 2'd0, 1'b0, 1'b0);

        // Reset with a result present and vsync toggling.
        cycle("reset_0", 1'b1, 1'b1, 1'b0, 2'd1, z);
        cycle("reset_1", 1'b1, 1'b0, 1'b0, 2'd1, z);
        cycle("post_reset_blink", 1'b0, 1'b0, 1'b0, 2'd1, mk(1'b1, 2'd1, 1'b1, 1'b0));

        // Reset during BLINK, then a player 2 win for the full sequence.
        cycle("reset_in_blink", 1'b1, 1'b0, 1'b0, 2'd1, z);
        cycle("play_idle", 1'b0, 1'b0, 1'b0, 2'd0, z);
        cycle("enter_blink_p2", 1'b0, 1'b0, 1'b0, 2'd2, mk(1'b1, 2'd2, 1'b1, 1'b0));
        run_blink(2'd2, 2'd1);

        // Button pressed in HOLD and held into WAIT: no restart until a fresh edge.
        run_hold(2'd2, 1'b1, 3);
        for (int i = 0; i < 3; i++)
            cycle("wait_btn_held", 1'b0, 1'b0, 1'b1, 2'd2, mk(1'b1, 2'd2, 1'b1, 1'b0));
        for (int i = 0; i < 2; i++)
            cycle("wait_btn_low", 1'b0, 1'b0, 1'b0, 2'd2, mk(1'b1, 2'd2, 1'b1, 1'b0));
        cycle("restart_pulse", 1'b0, 1'b0, 1'b1, 2'd2, mk(1'b0, 2'd0, 1'b1, 1'b1));
        cycle("restart_done", 1'b0, 1'b0, 1'b1, 2'd2, z);

        // Re-arm: result still 2 keeps PLAY idle until 0 is seen.
        for (int i = 0; i < 3; i++)
            frame("no_rearm", 1'b0, 2'd2, z);
        cycle("rearm", 1'b0, 1'b0, 1'b0, 2'd0, z);
        cycle("enter_blink_p1", 1'b0, 1'b0, 1'b0, 2'd1, mk(1'b1, 2'd1, 1'b1, 1'b0));
        run_blink(2'd1, 2'd3);
        run_hold(2'd1, 1'b0, 1);

        // Reset in HOLD: outputs drop on the next edge with no restart pulse.
        cycle("reset_in_hold", 1'b1, 1'b0, 1'b0, 2'd3, z);
        cycle("enter_blink_draw", 1'b0, 1'b0, 1'b0, 2'd3, mk(1'b1, 2'd3, 1'b1, 1'b0));
        run_blink(2'd3, 2'd0);
        run_hold(2'd3, 1'b0, 3);

`ifdef GAMEOVER_AUTO_RESTART_EN
        // Automatic restart on the 4th tick in WAIT.
        for (int i = 0; i < 3; i++)
            frame("auto_wait", 1'b0, 2'd3, mk(1'b1, 2'd3, 1'b1, 1'b0));
        cycle("auto_restart", 1'b0, 1'b1, 1'b0, 2'd3, mk(1'b0, 2'd0, 1'b1, 1'b1));
        cycle("auto_done", 1'b0, 1'b0, 1'b0, 2'd3, z);
`else
        // Without auto restart, WAIT persists across many frames.
        for (int i = 0; i < 5; i++)
            frame("wait_stays", 1'b0, 2'd3, mk(1'b1, 2'd3, 1'b1, 1'b0));
        cycle("btn_restart", 1'b0, 1'b0, 1'b1, 2'd3, mk(1'b0, 2'd0, 1'b1, 1'b1));
        cycle("btn_done", 1'b0, 1'b0, 1'b0, 2'd3, z);
`endif

        // Button edge coinciding with the 4th WAIT tick: exactly one restart pulse.
        cycle("rearm2", 1'b0, 1'b0, 1'b0, 2'd0, z);
        cycle("enter_blink_p2b", 1'b0, 1'b0, 1'b0, 2'd2, mk(1'b1, 2'd2, 1'b1, 1'b0));
        run_blink(2'd2, 2'd2);
        run_hold(2'd2, 1'b0, 3);
        for (int i = 0; i < 3; i++)
            frame("wait_pre_coincide", 1'b0, 2'd2, mk(1'b1, 2'd2, 1'b1, 1'b0));
        cycle("coincide_restart", 1'b0, 1'b1, 1'b1, 2'd2, mk(1'b0, 2'd0, 1'b1, 1'b1));
        cycle("coincide_single", 1'b0, 1'b0, 1'b1, 2'd2, z);
        for (int i = 0; i < 2; i++)
            frame("after_coincide", 1'b0, 2'd2, z);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
